// File: rtl/ln_cordic_pkg.sv
// Shared types and constants for the ln CORDIC control path (state encoding, repeat indices).
// Pure definitions: no latency, no flow control.
package ln_cordic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ITER = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Hyperbolic vectoring only converges if these shift indices run twice.
  localparam int REPEAT_IDX_A = 4;
  localparam int REPEAT_IDX_B = 13;

  function automatic int iter_steps(input int n_iter);
    return n_iter + 2;
  endfunction

endpackage

// File: rtl/ln_cordic_idx_gen.sv
// Iteration index counter with repeat flag: CLR loads index 1, ADV steps 1,2,3,4,4,...,13,13,...
// LAST is combinational from registered state; no backpressure, ADV is taken every asserted cycle.
module ln_cordic_idx_gen
  import ln_cordic_pkg::*;
#(
  parameter int ROM_WIDTH = 5,
  parameter int N_ITER    = 24
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 CLR,
  input  logic                 ADV,
  output logic [ROM_WIDTH-1:0] IDX,
  output logic                 LAST
);

  logic [ROM_WIDTH-1:0] idx_q, idx_d;
  logic                 rep_q, rep_d;
  logic                 rep_pending;

  assign rep_pending = ((idx_q == ROM_WIDTH'(REPEAT_IDX_A)) ||
                        (idx_q == ROM_WIDTH'(REPEAT_IDX_B))) && !rep_q;

  always_comb begin
    idx_d = idx_q;
    rep_d = rep_q;
    if (CLR) begin
      idx_d = ROM_WIDTH'(1);
      rep_d = 1'b0;
    end else if (ADV) begin
      if (rep_pending) begin
        rep_d = 1'b1;
      end else begin
        idx_d = idx_q + ROM_WIDTH'(1);
        rep_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      idx_q <= '0;
      rep_q <= 1'b0;
    end else begin
      idx_q <= idx_d;
      rep_q <= rep_d;
    end
  end

  assign IDX  = idx_q;
  assign LAST = (idx_q == ROM_WIDTH'(N_ITER)) && !rep_pending;

endmodule

// File: rtl/ln_cordic_sequencer.sv
// Control FSM for hyperbolic-vectoring ln CORDIC: START -> LOAD -> N_ITER+2 ITER steps -> DONE pulse.
// START is accepted only while READY; invalid operands (<=0) go straight to DONE with INVALID set.
module ln_cordic_sequencer
  import ln_cordic_pkg::*;
#(
  parameter int ROM_WIDTH = 5,
  parameter int N_ITER    = 24
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic                 SIGN_IN,
  input  logic                 ZERO_IN,
  input  logic                 SIGN_Y,
  output logic                 READY,
  output logic                 BUSY,
  output logic                 LOAD_EN,
  output logic                 ITER_EN,
  output logic [ROM_WIDTH-1:0] ROM_ADDR,
  output logic                 DIR,
  output logic                 DONE,
  output logic                 INVALID
);

  generate
    if (N_ITER < REPEAT_IDX_B || N_ITER > (2**ROM_WIDTH) - 1) begin : g_bad_niter
      $error("N_ITER out of legal range for ROM_WIDTH");
    end
  endgenerate

  state_t               state_q, state_d;
  logic                 inv_q, inv_d;
  logic                 idx_clr, idx_adv, idx_last;
  logic [ROM_WIDTH-1:0] idx;

  ln_cordic_idx_gen #(
    .ROM_WIDTH (ROM_WIDTH),
    .N_ITER    (N_ITER)
  ) u_idx_gen (
    .CLK  (CLK),
    .RST  (RST),
    .CLR  (idx_clr),
    .ADV  (idx_adv),
    .IDX  (idx),
    .LAST (idx_last)
  );

  always_comb begin
    state_d = state_q;
    inv_d   = inv_q;
    idx_clr = 1'b0;
    idx_adv = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          inv_d   = SIGN_IN | ZERO_IN;
          state_d = (SIGN_IN | ZERO_IN) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        idx_clr = 1'b1;
        state_d = ST_ITER;
      end
      ST_ITER: begin
        idx_adv = 1'b1;
        if (idx_last) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      inv_q   <= inv_d;
    end
  end

  assign READY    = (state_q == ST_IDLE);
  assign BUSY     = (state_q == ST_LOAD) || (state_q == ST_ITER);
  assign LOAD_EN  = (state_q == ST_LOAD);
  assign ITER_EN  = (state_q == ST_ITER);
  assign DONE     = (state_q == ST_DONE);
  assign INVALID  = DONE && inv_q;
  // The index register keeps its last value after DONE, so mask it outside ITER.
  assign ROM_ADDR = ITER_EN ? idx : '0;
  assign DIR      = ITER_EN && SIGN_Y;

endmodule

// File: doc/ln_cordic_sequencer.md
# ln_cordic_sequencer

Control FSM for the natural-logarithm CORDIC datapath, running hyperbolic vectoring. It accepts a start request and screens out invalid operands. It then drives the datapath load strobe, per-iteration enable, shift index / atanh ROM address and rotation direction, using the sign of Y reported by the SIGN block. When the iteration schedule finishes, it pulses DONE.

## Interface
- ROM_WIDTH, 5: width of the atanh ROM address and of the shift index.
- N_ITER, 24: last iteration index. Legal range is 13..2^ROM_WIDTH-1; synthesis errors outside it.
- CLK  in  1  rising-edge clock.
- RST  in  1  reset, asynchronous, active-high.
- START  in  1  request; sampled only while READY=1.
- SIGN_IN  in  1  sign of operand; 1 = negative.
- ZERO_IN  in  1  operand is zero.
- SIGN_Y  in  1  current Y sign from the SIGN block; 1 = negative.
- READY  out  1  idle, can accept START.
- BUSY  out  1  LOAD or ITER in progress.
- LOAD_EN  out  1  datapath loads x=a+1, y=a-1, z=0.
- ITER_EN  out  1  datapath performs one micro-rotation.
- ROM_ADDR  out  ROM_WIDTH  iteration index i; also the shift amount.
- DIR  out  1  rotation direction for this iteration.
- DONE  out  1  one-cycle completion pulse.
- INVALID  out  1  qualifies DONE: operand was ≤ 0, no result.

## Operation
- States and transitions:
  - IDLE: START=1 with SIGN_IN=0 and ZERO_IN=0 → LOAD. START=1 with SIGN_IN=1 or ZERO_IN=1 → DONE, with the invalid flag set.
  - LOAD: unconditionally → ITER, with i=1 and the repeat flag cleared.
  - ITER: on the last step (i=N_ITER, no repeat pending) → DONE. Otherwise stay in ITER and advance the index.
  - DONE: unconditionally → IDLE.
- Index schedule: 1, 2, 3, 4, 4, 5, …, 13, 13, 14, …, N_ITER.
  - Indices 4 and 13 execute twice, as required for hyperbolic convergence.
  - Total ITER steps S = N_ITER+2.
- Repeat logic: a one-bit repeat flag.
  - At i ∈ {4,13} with the flag clear: hold i and set the flag.
  - Otherwise: i ← i+1 and clear the flag.
- Outputs are decoded from registered state, index and invalid flag:
  - READY = IDLE; BUSY = LOAD|ITER.
  - LOAD_EN = LOAD; ITER_EN = ITER; DONE = DONE state.
  - ROM_ADDR = index register, and 0 outside ITER.
  - INVALID = DONE & invalid flag.
- DIR = ITER & SIGN_Y, combinational. 1 means y += x>>i, x += y>>i, z −= atanh(2^-i); 0 means the opposite signs.
- Ignored inputs:
  - START outside IDLE is ignored, including START held high through DONE. A new request is accepted at the earliest in the cycle READY reasserts.
  - SIGN_IN and ZERO_IN are ignored outside IDLE.
- Reset, at power-up or mid-operation: asynchronous return to IDLE; index=0, repeat flag=0, invalid flag=0.
  - Outputs during and after reset: READY=1, all other outputs 0, ROM_ADDR=0.
  - No DONE pulse for an aborted operation.

## Timing
- c0 is the cycle in which START=1 and READY=1.
- Valid operand:
  - c1: LOAD_EN=1.
  - c2..c(S+1): ITER_EN=1.
  - c(S+2): DONE=1.
  - c(S+3): READY=1.
  - Defaults give ITER c2..c27, DONE c28, READY c29: 29 cycles start to ready.
- Invalid operand: c1 DONE=1 with INVALID=1; c2 READY=1. LOAD_EN and ITER_EN never assert.
- SIGN_Y must be valid combinationally in each ITER cycle; the datapath registers it with ITER_EN.
- Back-to-back requests: minimum spacing S+3 cycles.

## Structure
- Shared package ln_cordic_pkg holds:
  - the state enum (IDLE, LOAD, ITER, DONE);
  - constants REPEAT_IDX_A=4 and REPEAT_IDX_B=13;
  - the function computing S from N_ITER.
- One natural sub-module: ln_cordic_idx_gen, the index counter plus repeat flag. It has inputs CLK, RST, CLR, ADV and outputs IDX and LAST.

## Test plan
- Reset, then START=1 with SIGN_IN=0 and ZERO_IN=0 → LOAD_EN at c1; ITER_EN c2..c27; ROM_ADDR sequence 1,2,3,4,4,5…13,13,14…24; DONE at c28 with INVALID=0; READY at c29.
- START with SIGN_IN=1, then again with ZERO_IN=1 → each gives DONE and INVALID at c1 and READY at c2, with no LOAD_EN or ITER_EN.
- SIGN_Y toggled every ITER cycle → DIR equals SIGN_Y in ITER cycles and 0 in all other states.
- START held high continuously for 100 cycles → operations start at c0, c29, c58…, with no extra LOAD_EN while BUSY.
- RST asserted asynchronously mid-cycle at ROM_ADDR=13 (first pass) → outputs go immediately to READY=1, everything else 0, with no DONE pulse. After release, a new START produces the full schedule beginning at index 1.
